pc_update_ctrl: RTL and testbench
=================================

Name: pc_update_ctrl

Overview:
- Sequencer that decides how and when the program counter is updated in the multicycle CPU. It also owns the PC register.
- Drives the 3-bit PC-source select of the next-PC multiplexer and consumes that multiplexer's output (pc_next).
- Issues pc_write and epc_write pulses and handles a multi-cycle wait for the exception vector read.
- Sits between the main control FSM, which issues one update request per instruction, and the PC/EPC registers.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into pc on reset.
- MEM_LAT, 2, cycles spent waiting for the exception-vector memory read (legal range 1..15).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- kind  input  3  request type: 0 SEQ, 1 BEQ, 2 BNE, 3 JUMP, 4 RTE, 5 EXC; 6 and 7 are reserved.
- zero  input  1  ALU zero flag; valid in the EVAL cycle.
- pc_next  input  32  output of the next-PC multiplexer.
- pc_source  output  3  multiplexer select: 0 PC+4, 1 branch target, 2 jump target, 3 EPC, 4 exception vector.
- pc_write  output  1  one-cycle strobe; pc loads on this cycle's edge.
- epc_write  output  1  one-cycle strobe to save the faulting PC into EPC.
- pc  output  32  current program counter.
- busy  output  1  request in progress.
- done  output  1  one-cycle completion pulse.
- align_err  output  1  one-cycle pulse when a written target has pc_next[1:0] != 0.

Behaviour:
- Reset values (synchronous; wins over all other inputs, including mid-operation): pc=RESET_PC, state=IDLE, pc_source=0, and pc_write, epc_write, busy, done, align_err all 0. Any in-flight request is dropped and no write occurs.
- States: IDLE, EVAL, EXC_WAIT, WRITE, DONE.
- IDLE/DONE, start=1: kind is latched and the FSM goes to EVAL; busy=1 from the next cycle.
- IDLE/DONE, start=0: go to (or stay in) IDLE.
- start while busy=1 is ignored (not queued).
- EVAL: pc_source is registered from the latched kind:
  - SEQ: pc_source=0, next state WRITE.
  - BEQ: if zero=1, pc_source=1 and next state WRITE; else pc_source=0 and next state DONE with no write (not taken).
  - BNE: same as BEQ with the zero test inverted.
  - JUMP: pc_source=2, next state WRITE.
  - RTE: pc_source=3, next state WRITE.
  - EXC, and reserved kinds 6/7: epc_write=1 for this cycle only, pc_source=4, cycle counter loaded with MEM_LAT, next state EXC_WAIT.
- EXC_WAIT: counter decrements each cycle; go to WRITE after exactly MEM_LAT cycles in this state.
- WRITE: pc_write=1. On this edge pc <= {pc_next[31:2],2'b00}. align_err=1 in the same cycle if pc_next[1:0] != 0. Next state DONE.
- DONE: done=1 and busy=0 for exactly one cycle.
- pc_source holds its value from EVAL until the next EVAL; it is never glitched during WRITE.
- Latency, start sampled at cycle t:
  - EVAL at t+1, WRITE at t+2, new pc visible at t+3, done at t+3.
  - EXC: WRITE at t+2+MEM_LAT, done at t+3+MEM_LAT.
  - Not-taken branch: done at t+2, pc unchanged.
- Back-to-back: start asserted in the DONE cycle is accepted, giving one request every 3 cycles for the normal path.
- pc wraps naturally at 32 bits with no overflow detection.
- epc_write and pc_write are never high in the same cycle.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> pc=0, busy=0, done=0, pc_source=0; with start=0 nothing changes for 10 cycles.
- SEQ: pc=0, start with kind=0, pc_next=32'h4 -> pc_write high at t+2 only, pc=32'h4 at t+3, done at t+3, pc_source=0.
- Branches:
  - BEQ zero=1, pc_next=32'h40 -> pc_source=1, pc=32'h40 at t+3.
  - BEQ zero=0 -> no pc_write, done at t+2, pc unchanged.
  - BNE with the zero values swapped -> mirror results.
- EXC with MEM_LAT=2, pc_next=32'h0000_00FC -> epc_write only at t+1, pc_source=4, pc_write at t+4, pc=32'hFC at t+5, done at t+5.
  - kind=7 -> identical sequence.
- Boundaries:
  - start held high throughout a request -> only one request is accepted until DONE, then a second is accepted in the DONE cycle.
  - JUMP with pc_next=32'h0000_1002 -> pc=32'h1000, align_err pulses in the WRITE cycle.
  - pc=32'hFFFF_FFFC with SEQ pc_next=32'h0 -> pc=0.
- Reset mid-operation: assert reset during EXC_WAIT -> next cycle pc=RESET_PC, busy=0, no pc_write ever issued, and a fresh SEQ request afterwards behaves as in the SEQ scenario.

Source files
------------

// File: rtl/pc_update_ctrl.sv
// PC update sequencer for the multicycle CPU: owns the PC register and the
// next-PC mux select, and issues pc_write/epc_write strobes per request.
module pc_update_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_LAT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  kind,
  input  logic        zero,
  input  logic [31:0] pc_next,
  output logic [2:0]  pc_source,
  output logic        pc_write,
  output logic        epc_write,
  output logic [31:0] pc,
  output logic        busy,
  output logic        done,
  output logic        align_err
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EVAL     = 3'd1,
    ST_EXC_WAIT = 3'd2,
    ST_WRITE    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [2:0] KIND_SEQ  = 3'd0;
  localparam logic [2:0] KIND_BEQ  = 3'd1;
  localparam logic [2:0] KIND_BNE  = 3'd2;
  localparam logic [2:0] KIND_JUMP = 3'd3;
  localparam logic [2:0] KIND_RTE  = 3'd4;

  localparam logic [2:0] SRC_PC4    = 3'd0;
  localparam logic [2:0] SRC_BRANCH = 3'd1;
  localparam logic [2:0] SRC_JUMP   = 3'd2;
  localparam logic [2:0] SRC_EPC    = 3'd3;
  localparam logic [2:0] SRC_EXCVEC = 3'd4;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

  // EXC and the reserved encodings all take the exception path
  function automatic logic is_exc_kind(input logic [2:0] k);
    return (k >= 3'd5);
  endfunction

  function automatic logic is_busy_state(input state_t s);
    return (s == ST_EVAL) || (s == ST_EXC_WAIT) || (s == ST_WRITE);
  endfunction

  state_t      state_r, state_s;
  logic [2:0]  kind_r, kind_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [2:0]  src_r, src_s;
  logic        epc_s;
  logic [31:0] pc_r;
  logic        pc_write_r;
  logic        epc_write_r;
  logic        busy_r;
  logic        done_r;

  assign pc_source = src_r;
  assign pc_write  = pc_write_r;
  assign epc_write = epc_write_r;
  assign pc        = pc_r;
  assign busy      = busy_r;
  assign done      = done_r;
  // pc_next only settles during WRITE, so the misalignment flag follows it combinationally
  assign align_err = pc_write_r & (pc_next[1:0] != 2'b00);

  // Next-state, mux select and strobe decode
  always_comb begin
    state_s = state_r;
    kind_s  = kind_r;
    cnt_s   = cnt_r;
    src_s   = src_r;
    epc_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_EVAL;
          kind_s  = kind;
          epc_s   = is_exc_kind(kind);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EVAL: begin
        case (kind_r)
          KIND_SEQ: begin
            src_s   = SRC_PC4;
            state_s = ST_WRITE;
          end
          KIND_BEQ, KIND_BNE: begin
            if (zero ^ (kind_r == KIND_BNE)) begin
              src_s   = SRC_BRANCH;
              state_s = ST_WRITE;
            end else begin
              src_s   = SRC_PC4;
              state_s = ST_DONE;
            end
          end
          KIND_JUMP: begin
            src_s   = SRC_JUMP;
            state_s = ST_WRITE;
          end
          KIND_RTE: begin
            src_s   = SRC_EPC;
            state_s = ST_WRITE;
          end
          default: begin
            src_s   = SRC_EXCVEC;
            cnt_s   = LAT_LOAD;
            state_s = ST_EXC_WAIT;
          end
        endcase
      end
      ST_EXC_WAIT: begin
        if (cnt_r <= 4'd1) begin
          cnt_s   = 4'd0;
          state_s = ST_WRITE;
        end else begin
          cnt_s   = cnt_r - 4'd1;
        end
      end
      ST_WRITE: begin
        state_s = ST_DONE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      kind_r      <= 3'd0;
      cnt_r       <= 4'd0;
      src_r       <= SRC_PC4;
      pc_write_r  <= 1'b0;
      epc_write_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      kind_r      <= kind_s;
      cnt_r       <= cnt_s;
      src_r       <= src_s;
      pc_write_r  <= (state_s == ST_WRITE);
      epc_write_r <= epc_s;
      busy_r      <= is_busy_state(state_s);
      done_r      <= (state_s == ST_DONE);
    end
  end

  // PC register, loaded word-aligned at the end of the WRITE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (state_r == ST_WRITE) begin
      pc_r <= {pc_next[31:2], 2'b00};
    end else begin
      pc_r <= pc_r;
    end
  end

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Self-checking bench for pc_update_ctrl: directed scenarios plus randomized
// requests checked against a per-request timing/result model.
module tb_pc_update_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MEM_LAT  = 2;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  kind;
  logic        zero;
  logic [31:0] pc_next;
  logic [2:0]  pc_source;
  logic        pc_write;
  logic        epc_write;
  logic [31:0] pc;
  logic        busy;
  logic        done;
  logic        align_err;

  int n_cmp;
  int n_err;
  logic [31:0] exp_pc;
  logic [2:0]  exp_src;

  pc_update_ctrl #(.RESET_PC(RESET_PC), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .kind(kind), .zero(zero),
    .pc_next(pc_next), .pc_source(pc_source), .pc_write(pc_write),
    .epc_write(epc_write), .pc(pc), .busy(busy), .done(done),
    .align_err(align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_pcw", 32'(pc_write), 32'd0);
      chk("idle_epcw", 32'(epc_write), 32'd0);
      chk("idle_pc", pc, exp_pc);
      chk("idle_src", 32'(pc_source), 32'(exp_src));
    end
  endtask

  // One request issued in the current cycle (t); returns in its done cycle.
  // With hold=1 start stays high (with junk kinds) so the next request is
  // accepted in the done cycle.
  task automatic req(input logic [2:0] k, input logic z, input logic [31:0] pcn, input bit hold);
    bit          exc;
    bit          taken;
    int          wr;
    int          dn;
    logic [2:0]  src;
    logic [31:0] new_pc;
    exc = (k >= 3'd5);
    case (k)
      3'd0:    begin taken = 1'b1; src = 3'd0; end
      3'd1:    begin taken = z;    src = z ? 3'd1 : 3'd0; end
      3'd2:    begin taken = !z;   src = !z ? 3'd1 : 3'd0; end
      3'd3:    begin taken = 1'b1; src = 3'd2; end
      3'd4:    begin taken = 1'b1; src = 3'd3; end
      default: begin taken = 1'b1; src = 3'd4; end
    endcase
    wr = taken ? (exc ? 2 + MEM_LAT : 2) : 0;
    dn = taken ? wr + 1 : 2;
    new_pc = taken ? (pcn & 32'hFFFF_FFFC) : exp_pc;
    start = 1'b1;
    kind = k;
    zero = ~z;
    pc_next = pcn;
    for (int c = 1; c <= dn; c++) begin
      tick();
      if (c == 1) zero = z;
      else zero = 1'($urandom_range(0, 1));
      start = hold;
      if (hold) kind = 3'($urandom_range(0, 7));
      chk("pc_write", 32'(pc_write), 32'(c == wr));
      chk("epc_write", 32'(epc_write), 32'(c == 1 && exc));
      chk("done", 32'(done), 32'(c == dn));
      chk("busy", 32'(busy), 32'(c < dn));
      chk("align_err", 32'(align_err), 32'(c == wr && pcn[1:0] != 2'b00));
      chk("pc", pc, (wr != 0 && c > wr) ? new_pc : exp_pc);
      chk("pc_source", 32'(pc_source), 32'((c >= 2) ? src : exp_src));
    end
    exp_pc = new_pc;
    exp_src = src;
  endtask

  initial begin
    int gap;
    bit hold;
    logic [31:0] pcn;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    kind = 3'd0;
    zero = 1'b0;
    pc_next = 32'h0;
    tick();
    tick();
    exp_pc = RESET_PC;
    exp_src = 3'd0;
    chk("rst_pc", pc, RESET_PC);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_src", 32'(pc_source), 32'd0);
    chk("rst_pcw", 32'(pc_write), 32'd0);
    reset = 1'b0;
    idle(10);

    req(3'd0, 1'b0, 32'h0000_0004, 1'b0);          // SEQ
    idle(1);
    req(3'd1, 1'b1, 32'h0000_0040, 1'b0);          // BEQ taken
    idle(1);
    req(3'd1, 1'b0, 32'h0000_0080, 1'b0);          // BEQ not taken
    req(3'd2, 1'b0, 32'h0000_0100, 1'b0);          // BNE taken
    req(3'd2, 1'b1, 32'h0000_0200, 1'b0);          // BNE not taken
    idle(2);
    req(3'd5, 1'b0, 32'h0000_00FC, 1'b0);          // EXC
    idle(1);
    req(3'd7, 1'b1, 32'h0000_00FC, 1'b0);          // reserved kind behaves as EXC
    req(3'd4, 1'b0, 32'h0000_0300, 1'b1);          // start held high through request
    req(3'd3, 1'b0, 32'h0000_1002, 1'b0);          // misaligned jump
    idle(1);
    req(3'd3, 1'b0, 32'hFFFF_FFFC, 1'b0);
    req(3'd0, 1'b0, 32'h0000_0000, 1'b0);          // wrap to zero
    idle(1);

    // Reset during EXC_WAIT drops the request without a write
    start = 1'b1;
    kind = 3'd5;
    pc_next = 32'h0000_0500;
    tick();
    start = 1'b0;
    tick();
    chk("mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_pc = RESET_PC;
    exp_src = 3'd0;
    chk("mid_pc", pc, RESET_PC);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_pcw", 32'(pc_write), 32'd0);
    idle(6);
    req(3'd0, 1'b0, 32'h0000_0004, 1'b0);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      pcn = $urandom;
      if ($urandom_range(0, 3) != 0) pcn[1:0] = 2'b00;
      hold = ($urandom_range(0, 3) == 0) && (i != 39);
      req(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pcn, hold);
      gap = hold ? 0 : $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
